fetch_stage: RTL and testbench

//  IF stage + IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of ctrl_unit.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_pc_unit.sv | 59 +++++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  // Encoding of an empty slot in the IF/ID register (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam int unsigned INSTR_BYTES = 4;

  // Fetch controller states.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // request outstanding, waiting for ack
    S_HELD  = 2'd1,  // word captured during a stall, bus idle
    S_DRAIN = 2'd2   // redirect pending behind an in-flight request
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter datapath: PC register, +4 adder, target mux and the
// redirect register that parks a branch target while a fetch drains.
module fetch_pc_unit
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                load_target_i,
  input  logic                load_redir_i,
  input  logic                capture_redir_i,
  input  logic [PC_WIDTH-1:0] br_target_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc4_o
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] RESET_ALIGN = RESET_PC & ALIGN_MASK;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] redir_q, redir_d;
  logic [PC_WIDTH-1:0] targetAligned;

  // Branch targets are forced word aligned so pc[1:0] can never become nonzero.
  assign targetAligned = br_target_i & ALIGN_MASK;
  assign pc4_o         = pc_q + PC_WIDTH'(INSTR_BYTES);
  assign pc_o          = pc_q;

  // Next PC selection: a fresh branch beats a parked redirect, which beats sequential advance.
  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    if (load_target_i) begin
      pc_d = targetAligned;
    end else if (load_redir_i) begin
      pc_d = redir_q;
    end else if (inc_i) begin
      pc_d = pc4_o;
    end
    if (capture_redir_i) begin
      redir_d = targetAligned;
    end
  end

  // PC and redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_ALIGN;
      redir_q <= '0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register. Fetches over a req/ack bus of
// variable latency, honours the load-use stall and taken-branch redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                cu_wpcir,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic [31:0]         if_instr,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc4
);

  fetch_state_e        state_q, state_d;
  logic [31:0]         idInstr_q, idInstr_d;
  logic [PC_WIDTH-1:0] idPc4_q, idPc4_d;
  logic [31:0]         hold_q, hold_d;

  logic [PC_WIDTH-1:0] pc, pc4;
  logic                pcInc, pcLoadTarget, pcLoadRedir, redirCapture;
  logic                ackValid;

  fetch_pc_unit #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk             (clk),
    .rst             (rst),
    .inc_i           (pcInc),
    .load_target_i   (pcLoadTarget),
    .load_redir_i    (pcLoadRedir),
    .capture_redir_i (redirCapture),
    .br_target_i     (br_target),
    .pc_o            (pc),
    .pc4_o           (pc4)
  );

  // The address is the PC itself; it only moves on an ack, so it is stable mid-request.
  assign imem_addr = pc;
  assign imem_req  = rst && (state_q != S_HELD);
  assign ackValid  = imem_ack && imem_req;
  assign id_instr  = idInstr_q;
  assign id_pc4    = idPc4_q;

  // Instruction shown to the control unit for hazard detection this cycle.
  always_comb begin
    if_instr = NOP_INSTR;
    if (rst) begin
      if (state_q == S_REQ && ackValid) begin
        if_instr = imem_rdata;
      end else if (state_q == S_HELD) begin
        if_instr = hold_q;
      end
    end
  end

  // Fetch controller: branch beats stall beats normal flow in every state.
  always_comb begin
    state_d      = state_q;
    idInstr_d    = idInstr_q;
    idPc4_d      = idPc4_q;
    hold_d       = hold_q;
    pcInc        = 1'b0;
    pcLoadTarget = 1'b0;
    pcLoadRedir  = 1'b0;
    redirCapture = 1'b0;
    case (state_q)
      S_REQ: begin
        if (ackValid) begin
          if (br_taken) begin
            pcLoadTarget = 1'b1;
            idInstr_d    = NOP_INSTR;
          end else if (cu_wpcir) begin
            hold_d  = imem_rdata;
            state_d = S_HELD;
          end else begin
            idInstr_d = imem_rdata;
            idPc4_d   = pc4;
            pcInc     = 1'b1;
          end
        end else begin
          if (br_taken) begin
            redirCapture = 1'b1;
            idInstr_d    = NOP_INSTR;
            state_d      = S_DRAIN;
          end else if (!cu_wpcir) begin
            idInstr_d = NOP_INSTR;
          end
        end
      end
      S_HELD: begin
        if (br_taken) begin
          hold_d       = NOP_INSTR;
          pcLoadTarget = 1'b1;
          idInstr_d    = NOP_INSTR;
          state_d      = S_REQ;
        end else if (!cu_wpcir) begin
          idInstr_d = hold_q;
          idPc4_d   = pc4;
          pcInc     = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_DRAIN: begin
        idInstr_d = NOP_INSTR;
        if (ackValid) begin
          state_d = S_REQ;
          if (br_taken) begin
            pcLoadTarget = 1'b1;
          end else begin
            pcLoadRedir = 1'b1;
          end
        end else if (br_taken) begin
          redirCapture = 1'b1;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State, IF/ID and stall hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_REQ;
      idInstr_q <= NOP_INSTR;
      idPc4_q   <= '0;
      hold_q    <= NOP_INSTR;
    end else begin
      state_q   <= state_d;
      idInstr_q <= idInstr_d;
      idPc4_q   <= idPc4_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: latency-programmable memory responder and a
// scoreboard queue of expected IF/ID contents.
module tb_fetch_stage;

  localparam logic [31:0] LW_WORD = 32'h8C08_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } expT;

  logic        clk;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        cuWpcir;
  logic        brTaken;
  logic [31:0] brTarget;
  logic [31:0] ifInstr;
  logic [31:0] idInstr;
  logic [31:0] idPc4;

  int  latency;
  int  waitCnt;
  expT expQ[$];
  int  checks = 0;
  int  fails  = 0;

  fetch_stage #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imemReq),
    .imem_addr  (imemAddr),
    .imem_ack   (imemAck),
    .imem_rdata (imemRdata),
    .cu_wpcir   (cuWpcir),
    .br_taken   (brTaken),
    .br_target  (brTarget),
    .if_instr   (ifInstr),
    .id_instr   (idInstr),
    .id_pc4     (idPc4)
  );

  // Memory image: a load at 0x4, otherwise a word tagged with its address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h4) return LW_WORD;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imemRdata = memWord(imemAddr);
  assign imemAck   = imemReq && (waitCnt >= latency);

  // Counts wait cycles of the current request so ack arrives after `latency` cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) waitCnt <= 0;
    else if (!imemReq || imemAck) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic doReset;
    rst      = 1'b0;
    cuWpcir  = 1'b0;
    brTaken  = 1'b0;
    brTarget = 32'h0;
    latency  = 0;
    expQ.delete();
    #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cuWpcir = 1'b0; brTaken = 1'b0; brTarget = 32'h0; latency = 0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (imemReq !== 1'b0 || imemAddr !== 32'h0 || idInstr !== 32'h0 || idPc4 !== 32'h0 || ifInstr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_state: req=%b addr=%h id_instr=%h id_pc4=%h if_instr=%h, required 0 for all", imemReq, imemAddr, idInstr, idPc4, ifInstr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_release: req=%b addr=%h, required 1 / 00000000", imemReq, imemAddr);
    end
  endtask

  task automatic test_zero_wait;
    expT e;
    logic [31:0] a;
    doReset();
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== a || ifInstr !== memWord(a)) begin
        fails++;
        $display("[TB] FAIL zw_fetch%0d: req=%b addr=%h if_instr=%h, required 1 %h %h", i, imemReq, imemAddr, ifInstr, a, memWord(a));
      end
      expQ.push_back('{memWord(a), a + 32'd4});
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL zw_ifid%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
    end
  endtask

  task automatic test_latency;
    expT e;
    logic [31:0] a;
    logic [31:0] pc4Prev;
    doReset();
    latency = 1;
    pc4Prev = 32'h0;
    #1;
    for (int i = 0; i < 3; i++) begin
      a = 32'(4 * i);
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== a || ifInstr !== 32'h0) begin
        fails++;
        $display("[TB] FAIL lat_wait%0d: req=%b addr=%h if_instr=%h, required 1 %h 0", i, imemReq, imemAddr, ifInstr, a);
      end
      expQ.push_back('{32'h0, pc4Prev});
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL lat_bubble%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
      #1;
      checks++;
      if (imemAddr !== a || ifInstr !== memWord(a)) begin
        fails++;
        $display("[TB] FAIL lat_ack%0d: addr=%h if_instr=%h, required %h %h", i, imemAddr, ifInstr, a, memWord(a));
      end
      expQ.push_back('{memWord(a), a + 32'd4});
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL lat_ifid%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
      pc4Prev = a + 32'd4;
      #1;
    end
  endtask

  task automatic test_stall;
    expT e;
    doReset();
    expQ.push_back('{memWord(32'h0), 32'h4});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL stall_first: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    cuWpcir = 1'b1;
    #1;
    checks++;
    if (ifInstr !== LW_WORD || imemReq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_lw_seen: if_instr=%h req=%b, required %h 1", ifInstr, imemReq, LW_WORD);
    end
    expQ.push_back('{memWord(32'h0), 32'h4});
    @(posedge clk); #1;
    cuWpcir = 1'b0;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL stall_ifid_hold: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    #1;
    checks++;
    if (imemReq !== 1'b0 || ifInstr !== LW_WORD || imemAddr !== 32'h4) begin
      fails++;
      $display("[TB] FAIL stall_held: req=%b if_instr=%h addr=%h, required 0 %h 00000004", imemReq, ifInstr, imemAddr, LW_WORD);
    end
    expQ.push_back('{LW_WORD, 32'h8});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL stall_release: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h8) begin
      fails++;
      $display("[TB] FAIL stall_pc_once: req=%b addr=%h, required 1 00000008", imemReq, imemAddr);
    end
    expQ.push_back('{memWord(32'h8), 32'hC});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL stall_resume: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
  endtask

  task automatic test_drain;
    expT e;
    logic [31:0] a;
    doReset();
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      expQ.push_back('{memWord(a), a + 32'd4});
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL drain_pre%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
    end
    latency  = 2;
    brTaken  = 1'b1;
    brTarget = 32'h43;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (imemReq !== 1'b1 || imemAddr !== 32'h10 || ifInstr !== 32'h0) begin
        fails++;
        $display("[TB] FAIL drain_wait%0d: req=%b addr=%h if_instr=%h, required 1 00000010 0", i, imemReq, imemAddr, ifInstr);
      end
      expQ.push_back('{32'h0, 32'h10});
      @(posedge clk); #1;
      brTaken = 1'b0;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL drain_ifid%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
    end
    latency = 0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
      fails++;
      $display("[TB] FAIL drain_redirect: req=%b addr=%h, required 1 00000040", imemReq, imemAddr);
    end
    expQ.push_back('{memWord(32'h40), 32'h44});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL drain_target: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
  endtask

  task automatic test_branch_vs_stall;
    expT e;
    doReset();
    expQ.push_back('{memWord(32'h0), 32'h4});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL bvs_first: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    brTaken  = 1'b1;
    cuWpcir  = 1'b1;
    brTarget = 32'h80;
    expQ.push_back('{32'h0, 32'h4});
    @(posedge clk); #1;
    brTaken = 1'b0;
    cuWpcir = 1'b0;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL bvs_squash: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h80 || ifInstr !== memWord(32'h80)) begin
      fails++;
      $display("[TB] FAIL bvs_target: req=%b addr=%h if_instr=%h, required 1 00000080 %h", imemReq, imemAddr, ifInstr, memWord(32'h80));
    end
    expQ.push_back('{memWord(32'h80), 32'h84});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL bvs_after: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    brTaken  = 1'b1;
    brTarget = 32'hFFFF_FFFF;
    expQ.push_back('{32'h0, 32'h84});
    @(posedge clk); #1;
    brTaken = 1'b0;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL wrap_branch: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    #1;
    checks++;
    if (imemAddr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("[TB] FAIL wrap_align: addr=%h, required fffffffc", imemAddr);
    end
    expQ.push_back('{memWord(32'hFFFF_FFFC), 32'h0});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4 || imemAddr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL wrap_pc4: id_instr=%h id_pc4=%h addr=%h, required %h %h 00000000", idInstr, idPc4, imemAddr, e.instr, e.pc4);
    end
  endtask

  task automatic test_async_reset;
    expT e;
    doReset();
    expQ.push_back('{memWord(32'h0), 32'h4});
    expQ.push_back('{LW_WORD, 32'h8});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = expQ.pop_front();
      checks++;
      if (idInstr !== e.instr || idPc4 !== e.pc4) begin
        fails++;
        $display("[TB] FAIL ar_pre%0d: id_instr=%h id_pc4=%h, required %h %h", i, idInstr, idPc4, e.instr, e.pc4);
      end
    end
    latency = 3;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b0 || imemAddr !== 32'h0 || idInstr !== 32'h0 || idPc4 !== 32'h0 || ifInstr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL ar_midreq: req=%b addr=%h id_instr=%h id_pc4=%h if_instr=%h, required 0 for all", imemReq, imemAddr, idInstr, idPc4, ifInstr);
    end
    @(negedge clk);
    rst = 1'b1;
    latency = 0;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL ar_restart: req=%b addr=%h, required 1 00000000", imemReq, imemAddr);
    end
    expQ.push_back('{memWord(32'h0), 32'h4});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL ar_refetch: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
    cuWpcir = 1'b1;
    @(posedge clk); #1;
    cuWpcir = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b0 || ifInstr !== LW_WORD) begin
      fails++;
      $display("[TB] FAIL ar_enter_held: req=%b if_instr=%h, required 0 %h", imemReq, ifInstr, LW_WORD);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imemReq !== 1'b0 || imemAddr !== 32'h0 || idInstr !== 32'h0 || idPc4 !== 32'h0 || ifInstr !== 32'h0) begin
      fails++;
      $display("[TB] FAIL ar_held: req=%b addr=%h id_instr=%h id_pc4=%h if_instr=%h, required 0 for all", imemReq, imemAddr, idInstr, idPc4, ifInstr);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0 || ifInstr !== memWord(32'h0)) begin
      fails++;
      $display("[TB] FAIL ar_held_restart: req=%b addr=%h if_instr=%h, required 1 00000000 %h", imemReq, imemAddr, ifInstr, memWord(32'h0));
    end
    expQ.push_back('{memWord(32'h0), 32'h4});
    @(posedge clk); #1;
    e = expQ.pop_front();
    checks++;
    if (idInstr !== e.instr || idPc4 !== e.pc4) begin
      fails++;
      $display("[TB] FAIL ar_held_refetch: id_instr=%h id_pc4=%h, required %h %h", idInstr, idPc4, e.instr, e.pc4);
    end
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_drain();
    test_branch_vs_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
